coherent_demod_mc: RTL
======================

# coherent_demod_mc

Parametrised coherent demodulator for BPSK, ASK and QPSK on the receive path of the data-transmit chain. It multiplies the received samples by local in-phase and quadrature references and integrates the products over a programmable symbol length, with saturating accumulators. At each symbol boundary it emits a decision, a soft metric and a saturation flag. An external symbol-sync strobe and an input-valid handshake let the symbol-timing logic upstream steer it.

## Interface
- DATA_WIDTH, 12: width of received sample and references, signed two's complement
- SPS_WIDTH, 10: width of the samples-per-symbol setting
- ACC_WIDTH, 2*DATA_WIDTH+4: width of I/Q accumulators, threshold and metric
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = return to IDLE and clear state
- mode  in  2  00 BPSK, 01 ASK, 10 QPSK, 11 treated as BPSK
- sps  in  SPS_WIDTH  samples per symbol; 0 treated as 1
- ask_thresh  in  ACC_WIDTH  signed ASK decision threshold
- sym_sync  in  1  pulse: discard partial symbol, restart count
- in_valid  in  1  recv_sig/ref_i/ref_q valid this cycle
- recv_sig  in  DATA_WIDTH  signed received sample
- ref_i  in  DATA_WIDTH  signed local cosine
- ref_q  in  DATA_WIDTH  signed local sine
- busy  out  1  1 while in RUN
- out_valid  out  1  one-cycle decision strobe
- out_data  out  2  bit0 = I decision, bit1 = Q decision (QPSK only, else 0)
- out_metric  out  ACC_WIDTH  final signed I accumulator of the symbol
- out_sat  out  1  1 if either accumulator saturated during the symbol

## Operation
- States: IDLE, RUN. IDLE→RUN on enable=1. RUN→IDLE on enable=0, which takes priority over everything else. Leaving RUN clears the counter and accumulators and emits no out_valid.
- Accepted sample = RUN && in_valid. When in_valid=0, the counter and accumulators hold.
- On the first accepted sample of a symbol (cnt==0), mode, sps and ask_thresh are latched. Changes mid-symbol take effect at the next symbol.
- prod_i = recv_sig*ref_i and prod_q = recv_sig*ref_q, each 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
- acc_x_next = acc_x + prod_x, saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. A per-symbol sticky sat bit is set when either accumulator clamps.
- The last sample of a symbol is the accepted sample with cnt == sps_latched-1. On that edge:
  - Decide on acc_next (which includes the last sample).
  - Register out_valid=1, out_metric=acc_i_next, out_sat.
  - Clear the accumulators, counter and sticky bit.
- Decisions:
  - BPSK: bit0 = acc_i_next>=0.
  - ASK: bit0 = acc_i_next >= ask_thresh (signed).
  - QPSK: bit0 = acc_i_next>=0, bit1 = acc_q_next>=0.
  - bit1=0 in non-QPSK modes.
- sym_sync in RUN: clears the counter, accumulators and sticky bit. If in_valid is also high that cycle, the sample becomes sample 0 of the new symbol and config is latched. No out_valid is produced, even if that sample would have ended the symbol.
- sym_sync in IDLE is ignored.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_metric=0, out_sat=0, state IDLE, counter and accumulators 0.
- busy is registered and goes high the cycle after the enable edge. The first sample is accepted in the first cycle with busy=1.
- Latency: out_valid is high in the cycle immediately after the edge that accepted the last sample. It is exactly one cycle wide.
- out_data, out_metric and out_sat hold their values until the next out_valid or reset.
- sps=1 (or 0): every accepted sample yields out_valid the next cycle, so back-to-back strobes are possible.
- Counter wrap: cnt returns to 0 after the last sample. The maximum symbol is 2^SPS_WIDTH-1 samples.
- Reset mid-symbol: all state clears asynchronously and no out_valid is produced for the partial symbol.

## Test plan
- BPSK, sps=8, recv_sig=+100, ref_i=+100, in_valid=1 continuous → one out_valid after the 8th sample, out_data=01, out_metric=80000, out_sat=0. With recv_sig=-100 → out_data=00, out_metric=-80000.
- ASK, sps=8, ask_thresh=50000, amplitude 100 then 50 → out_data bit0 = 1 (metric 80000), then 0 (metric 40000).
- QPSK, sps=4, recv_sig=+100, ref_i=+100, ref_q=-100 → out_data=01, metric 40000. Flip ref_q to +100 → out_data=11.
- in_valid alternating 1/0, BPSK sps=8 → out_valid one cycle after the 8th accepted sample (16 cycles after start), metric 80000. Then sps=1 → out_valid on every cycle following each accepted sample.
- sym_sync after 3 samples, with in_valid high the same cycle, sps=8 → no strobe for the partial symbol; next out_valid arrives 8 samples after the sync, metric 80000. enable=0 mid-symbol → busy=0 next cycle, no out_valid.
- Saturation, defaults (ACC_WIDTH=28), sps=1023, recv_sig=ref_i=-2048 → out_metric=134217727, out_sat=1, out_data=01. Assert rst mid-symbol → all outputs 0 immediately.

Source files
------------

// File: rtl/coherent_demod_mc.sv
// coherent_demod_mc
//
// Coherent demodulator for BPSK / ASK / QPSK. Each accepted received sample is
// multiplied by the local in-phase and quadrature references; the products are
// integrated over a programmable number of samples in saturating accumulators.
// At the end of every symbol a decision, the final I accumulator (soft metric)
// and a sticky saturation flag are registered and strobed for one cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   enable      in   1 = run, 0 = return to IDLE and clear symbol state
//   mode        in   00 BPSK, 01 ASK, 10 QPSK, 11 BPSK
//   sps         in   samples per symbol (0 behaves as 1)
//   ask_thresh  in   signed ASK decision threshold
//   sym_sync    in   pulse: drop the partial symbol and restart the count
//   in_valid    in   recv_sig / ref_i / ref_q carry a sample this cycle
//   recv_sig    in   signed received sample
//   ref_i       in   signed local cosine
//   ref_q       in   signed local sine
//   busy        out  high while the FSM is in RUN (doubles as state debug)
//   out_valid   out  one-cycle decision strobe
//   out_data    out  bit0 = I decision, bit1 = Q decision (QPSK only)
//   out_metric  out  signed final I accumulator of the symbol
//   out_sat     out  an accumulator clamped during the symbol
//
// Handshake: there is no back-pressure. A sample is taken on every rising
// edge where the block is in RUN, enable is high and in_valid is high; with
// in_valid low everything holds. out_valid is a pure strobe, high for exactly
// one cycle; out_data/out_metric/out_sat stay stable until the next strobe.

module coherent_demod_mc #(
    parameter int DATA_WIDTH = 12,
    parameter int SPS_WIDTH  = 10,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [SPS_WIDTH-1:0]         sps,
    input  logic signed [ACC_WIDTH-1:0]  ask_thresh,
    input  logic                         sym_sync,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] recv_sig,
    input  logic signed [DATA_WIDTH-1:0] ref_i,
    input  logic signed [DATA_WIDTH-1:0] ref_q,
    output logic                         busy,
    output logic                         out_valid,
    output logic [1:0]                   out_data,
    output logic signed [ACC_WIDTH-1:0]  out_metric,
    output logic                         out_sat
);

    localparam int PW = 2*DATA_WIDTH;
    localparam logic [1:0] MODE_ASK  = 2'b01;
    localparam logic [1:0] MODE_QPSK = 2'b10;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t state_q, state_d;

    logic [SPS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
    logic [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
    logic                 sat_q, sat_d;
    logic [1:0]           mode_lat_q, mode_lat_d;
    logic [SPS_WIDTH-1:0] sps_lat_q, sps_lat_d;
    logic [ACC_WIDTH-1:0] thr_lat_q, thr_lat_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           out_data_q, out_data_d;
    logic [ACC_WIDTH-1:0] out_metric_q, out_metric_d;
    logic                 out_sat_q, out_sat_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);

    // ----------------------------------------------------------- datapath
    logic                        active, accept, sync, first, last;
    logic [SPS_WIDTH-1:0]        sps_in, sps_cur, cnt_cur;
    logic [1:0]                  mode_cur;
    logic [ACC_WIDTH-1:0]        thr_cur;
    logic signed [PW-1:0]        prod_i, prod_q;
    logic [ACC_WIDTH-1:0]        pe_i, pe_q, base_i, base_q, nx_i, nx_q;
    logic [ACC_WIDTH:0]          sum_i, sum_q;
    logic                        ovf_i, ovf_q, sat_nx;
    logic [1:0]                  dec;

    // enable=0 in RUN overrides everything, so nothing is accepted that cycle.
    assign active = busy && enable;
    assign accept = active && in_valid;
    assign sync   = active && sym_sync;

    assign prod_i = recv_sig * ref_i;
    assign prod_q = recv_sig * ref_q;
    assign pe_i   = {{(ACC_WIDTH-PW){prod_i[PW-1]}}, prod_i};
    assign pe_q   = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};

    always_comb begin
        // A sync sample is sample 0 of a fresh symbol: start from a cleared
        // counter/accumulator and use the live configuration.
        cnt_cur  = sync ? '0 : cnt_q;
        base_i   = sync ? '0 : acc_i_q;
        base_q   = sync ? '0 : acc_q_q;
        first    = (cnt_cur == '0);
        sps_in   = (sps == '0) ? SPS_WIDTH'(1) : sps;
        sps_cur  = first ? sps_in : sps_lat_q;
        mode_cur = first ? mode : mode_lat_q;
        thr_cur  = first ? ask_thresh : thr_lat_q;

        // One guard bit detects overflow; clamp toward the sign of the sum.
        sum_i = {base_i[ACC_WIDTH-1], base_i} + {pe_i[ACC_WIDTH-1], pe_i};
        sum_q = {base_q[ACC_WIDTH-1], base_q} + {pe_q[ACC_WIDTH-1], pe_q};
        ovf_i = sum_i[ACC_WIDTH] ^ sum_i[ACC_WIDTH-1];
        ovf_q = sum_q[ACC_WIDTH] ^ sum_q[ACC_WIDTH-1];
        nx_i  = ovf_i ? (sum_i[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_i[ACC_WIDTH-1:0];
        nx_q  = ovf_q ? (sum_q[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_q[ACC_WIDTH-1:0];
        sat_nx = ((sync ? 1'b0 : sat_q) | ovf_i | ovf_q);

        last = accept && (cnt_cur == (sps_cur - SPS_WIDTH'(1)));

        dec = 2'b00;
        if (mode_cur == MODE_ASK) dec[0] = ($signed(nx_i) >= $signed(thr_cur));
        else                      dec[0] = ~nx_i[ACC_WIDTH-1];
        if (mode_cur == MODE_QPSK) dec[1] = ~nx_q[ACC_WIDTH-1];
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        sat_d        = sat_q;
        mode_lat_d   = mode_lat_q;
        sps_lat_d    = sps_lat_q;
        thr_lat_d    = thr_lat_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_metric_d = out_metric_q;
        out_sat_d    = out_sat_q;

        if (!active) begin
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            sat_d   = 1'b0;
        end else if (accept) begin
            if (first) begin
                mode_lat_d = mode;
                sps_lat_d  = sps_in;
                thr_lat_d  = ask_thresh;
            end
            if (last) begin
                // A sync sample that would also close the symbol (sps=1)
                // is swallowed without a strobe.
                if (!sync) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = dec;
                    out_metric_d = nx_i;
                    out_sat_d    = sat_nx;
                end
                cnt_d   = '0;
                acc_i_d = '0;
                acc_q_d = '0;
                sat_d   = 1'b0;
            end else begin
                cnt_d   = cnt_cur + SPS_WIDTH'(1);
                acc_i_d = nx_i;
                acc_q_d = nx_q;
                sat_d   = sat_nx;
            end
        end else if (sync) begin
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            sat_q        <= 1'b0;
            mode_lat_q   <= '0;
            sps_lat_q    <= SPS_WIDTH'(1);
            thr_lat_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_metric_q <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            sat_q        <= sat_d;
            mode_lat_q   <= mode_lat_d;
            sps_lat_q    <= sps_lat_d;
            thr_lat_q    <= thr_lat_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_metric_q <= out_metric_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_metric = out_metric_q;
    assign out_sat    = out_sat_q;

endmodule
